universal_reg: RTL and testbench

Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with synchronous active-low reset, clock enable, and eight operating modes. The modes are hold, parallel load, logical shift left/right with serial input, rotate left/right, increment and decrement. A registered carry/borrow flag accompanies the register. The block serves as the general-purpose register/shifter/counter primitive for the CPU datapath (accumulator, shift unit, loop counter).

---
 rtl/universal_reg.sv | 110 +++++++++++
 tb/tb_universal_reg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/universal_reg.sv
// WIDTH-bit general-purpose register: load, shift, rotate and count with a
// registered carry/borrow flag, synchronous active-low reset and clock enable.
module universal_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic [2:0]       MODE,
   input  logic [WIDTH-1:0] D,
   input  logic             SIN,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_bar,
   output logic             CARRY,
   output logic             ZERO
);

   typedef enum logic [2:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_INC  = 3'b110,
      MODE_DEC  = 3'b111
   } mode_e;

   mode_e            mode_s;
   logic [WIDTH-1:0] q_r;
   logic             carry_r;
   logic [WIDTH-1:0] q_next_s;
   logic             carry_next_s;
   logic [WIDTH:0]   inc_s;
   logic [WIDTH-1:0] dec_s;
   logic             q_is_zero_s;

   assign mode_s      = mode_e'(MODE);
   // Increment is widened by one bit so the wrap-out lands directly in CARRY.
   assign inc_s       = {1'b0, q_r} + {{WIDTH{1'b0}}, 1'b1};
   assign dec_s       = q_r - {{(WIDTH-1){1'b0}}, 1'b1};
   assign q_is_zero_s = (q_r == {WIDTH{1'b0}});

   // Next-state selection for Q and CARRY from the current mode.
   always_comb begin
      q_next_s     = q_r;
      carry_next_s = carry_r;
      if (EN) begin
         case (mode_s)
            MODE_HOLD: begin
               q_next_s     = q_r;
               carry_next_s = carry_r;
            end
            MODE_LOAD: begin
               q_next_s     = D;
               carry_next_s = 1'b0;
            end
            MODE_SHL: begin
               q_next_s     = {q_r[WIDTH-2:0], SIN};
               carry_next_s = q_r[WIDTH-1];
            end
            MODE_SHR: begin
               q_next_s     = {SIN, q_r[WIDTH-1:1]};
               carry_next_s = q_r[0];
            end
            MODE_ROL: begin
               q_next_s     = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
               carry_next_s = q_r[WIDTH-1];
            end
            MODE_ROR: begin
               q_next_s     = {q_r[0], q_r[WIDTH-1:1]};
               carry_next_s = q_r[0];
            end
            MODE_INC: begin
               q_next_s     = inc_s[WIDTH-1:0];
               carry_next_s = inc_s[WIDTH];
            end
            MODE_DEC: begin
               q_next_s     = dec_s;
               carry_next_s = q_is_zero_s;
            end
            default: begin
               q_next_s     = q_r;
               carry_next_s = carry_r;
            end
         endcase
      end else begin
         q_next_s     = q_r;
         carry_next_s = carry_r;
      end
   end

   // State register; reset wins over enable and mode.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         q_r     <= RESET_VAL;
         carry_r <= 1'b0;
      end else begin
         q_r     <= q_next_s;
         carry_r <= carry_next_s;
      end
   end

   assign Q     = q_r;
   assign Q_bar = ~q_r;
   assign CARRY = carry_r;
   assign ZERO  = q_is_zero_s;

endmodule

// File: tb/tb_universal_reg.sv
// Scoreboard bench for universal_reg: two instances (RESET_VAL 0 and 8'h10)
// share stimulus; an arithmetic reference model predicts every edge.
module tb_universal_reg;

   logic       CLK;
   logic       RST_N;
   logic       EN;
   logic [2:0] MODE;
   logic [7:0] D;
   logic       SIN;
   logic [7:0] q0, qb0, q1, qb1;
   logic       c0, z0, c1, z1;

   int tests = 0;
   int fails = 0;

   int mq0, mc0, mq1, mc1;
   logic [8:0] exp0_q[$];
   logic [8:0] exp1_q[$];

   localparam logic [2:0] M_HOLD = 3'd0, M_LOAD = 3'd1, M_SHL = 3'd2, M_SHR = 3'd3,
                          M_ROL  = 3'd4, M_ROR  = 3'd5, M_INC = 3'd6, M_DEC = 3'd7;

   universal_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut0 (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .D(D), .SIN(SIN),
      .Q(q0), .Q_bar(qb0), .CARRY(c0), .ZERO(z0));

   universal_reg #(.WIDTH(8), .RESET_VAL(8'h10)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .D(D), .SIN(SIN),
      .Q(q1), .Q_bar(qb1), .CARRY(c1), .ZERO(z1));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference behaviour expressed as modulo-256 arithmetic.
   function automatic void model(input int q, input int c, input int rst, input int en,
                                 input int mode, input int d, input int sin, input int rv,
                                 output int nq, output int nc);
      nq = q;
      nc = c;
      if (rst == 0) begin
         nq = rv;
         nc = 0;
      end else if (en != 0) begin
         case (mode)
            1: begin nq = d;                          nc = 0;             end
            2: begin nq = (q * 2 + sin) % 256;        nc = q / 128;       end
            3: begin nq = sin * 128 + q / 2;          nc = q % 2;         end
            4: begin nq = (q * 2) % 256 + q / 128;    nc = q / 128;       end
            5: begin nq = (q % 2) * 128 + q / 2;      nc = q % 2;         end
            6: begin nq = (q + 1) % 256;              nc = (q == 255) ? 1 : 0; end
            7: begin nq = (q + 255) % 256;            nc = (q == 0) ? 1 : 0;   end
            default: ;
         endcase
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic sb_cmp(input string name, input logic [7:0] q, input logic [7:0] qb,
                         input logic c, input logic z, input logic [8:0] e);
      logic [7:0] eq;
      logic [17:0] got, exp;
      eq  = e[7:0];
      got = {c, z, q, qb};
      exp = {e[8], (eq == 8'h00), eq, ~eq};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got C=%b Z=%b Q=%h Qb=%h expected C=%b Z=%b Q=%h Qb=%h",
                  name, c, z, q, qb, e[8], (eq == 8'h00), eq, ~eq);
      end
   endtask

   // Drive one edge's inputs at negedge, predict both instances, return after the edge.
   task automatic step(input logic rst, input logic en, input logic [2:0] mode,
                       input logic [7:0] d, input logic sin);
      int nq, nc;
      @(negedge CLK);
      RST_N = rst; EN = en; MODE = mode; D = d; SIN = sin;
      model(mq0, mc0, rst, en, mode, d, sin, 8'h00, nq, nc);
      mq0 = nq; mc0 = nc;
      model(mq1, mc1, rst, en, mode, d, sin, 8'h10, nq, nc);
      mq1 = nq; mc1 = nc;
      exp0_q.push_back({mc0[0], mq0[7:0]});
      exp1_q.push_back({mc1[0], mq1[7:0]});
      @(posedge CLK);
      #2;
   endtask

   // Monitor: every edge that had stimulus is compared one time unit later.
   always @(posedge CLK) begin
      #1;
      if (exp0_q.size() > 0) sb_cmp("sb_dut0", q0, qb0, c0, z0, exp0_q.pop_front());
      if (exp1_q.size() > 0) sb_cmp("sb_dut1", q1, qb1, c1, z1, exp1_q.pop_front());
   end

   initial begin
      RST_N = 1'b0; EN = 1'b0; MODE = 3'd0; D = 8'h00; SIN = 1'b0;
      mq0 = 0; mc0 = 0; mq1 = 0; mc1 = 0;

      // Reset beats load
      step(1'b0, 1'b1, M_LOAD, 8'hFF, 1'b0);
      chk("reset_q", {24'd0, q0}, 32'h00);
      chk("reset_qbar", {24'd0, qb0}, 32'hFF);
      chk("reset_carry_zero", {30'd0, c0, z0}, 32'h1);
      chk("reset_q_rv10", {24'd0, q1}, 32'h10);

      // Load, D change while CLK high, enable-off hold
      step(1'b1, 1'b1, M_LOAD, 8'hA5, 1'b0);
      D = 8'h00;
      #1 chk("d_change_clk_high", {24'd0, q0}, 32'hA5);
      repeat (3) step(1'b1, 1'b0, M_LOAD, 8'h3C, 1'b0);
      chk("en_off_hold", {24'd0, q0}, 32'hA5);

      step(1'b1, 1'b1, M_LOAD, 8'h81, 1'b0);
      step(1'b1, 1'b1, M_SHL, 8'h00, 1'b0);
      chk("shl", {23'd0, c0, q0}, 32'h102);
      step(1'b1, 1'b1, M_LOAD, 8'h81, 1'b0);
      step(1'b1, 1'b1, M_SHR, 8'h00, 1'b1);
      chk("shr", {23'd0, c0, q0}, 32'h1C0);
      step(1'b1, 1'b1, M_LOAD, 8'h81, 1'b0);
      step(1'b1, 1'b1, M_ROL, 8'h00, 1'b0);
      chk("rol", {23'd0, c0, q0}, 32'h103);
      step(1'b1, 1'b1, M_LOAD, 8'h96, 1'b0);
      repeat (8) step(1'b1, 1'b1, M_ROR, 8'h00, 1'b0);
      chk("ror_x8", {24'd0, q0}, 32'h96);

      // Counter wrap boundaries
      step(1'b1, 1'b1, M_LOAD, 8'hFE, 1'b0);
      step(1'b1, 1'b1, M_INC, 8'h00, 1'b0);
      chk("inc_to_ff", {23'd0, c0, q0}, 32'h0FF);
      step(1'b1, 1'b1, M_INC, 8'h00, 1'b0);
      chk("inc_wrap", {22'd0, c0, z0, q0}, 32'h300);
      step(1'b1, 1'b1, M_DEC, 8'h00, 1'b0);
      chk("dec_wrap", {22'd0, c0, z0, q0}, 32'h2FF);
      step(1'b1, 1'b1, M_LOAD, 8'h01, 1'b0);
      step(1'b1, 1'b1, M_DEC, 8'h00, 1'b0);
      chk("dec_to_zero", {22'd0, c0, z0, q0}, 32'h100);

      // Reset asserted between edges has no effect until the next posedge
      step(1'b1, 1'b1, M_LOAD, 8'h55, 1'b0);
      RST_N = 1'b0;
      #1 chk("reset_between_edges", {24'd0, q0}, 32'h55);
      step(1'b0, 1'b1, M_INC, 8'h00, 1'b0);
      chk("reset_applied", {24'd0, q0}, 32'h00);

      // Reset mid-count on the RESET_VAL=8'h10 instance
      repeat (5) step(1'b1, 1'b1, M_INC, 8'h00, 1'b0);
      chk("rv10_inc5", {24'd0, q1}, 32'h15);
      step(1'b0, 1'b1, M_INC, 8'h00, 1'b0);
      chk("rv10_reset_mid", {23'd0, c1, q1}, 32'h010);
      step(1'b1, 1'b1, M_INC, 8'h00, 1'b0);
      chk("rv10_inc_after", {24'd0, q1}, 32'h11);

      // Randomized traffic, scoreboarded edge by edge
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
              3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end

      begin : drain
         int budget;
         budget = 10;
         while ((exp0_q.size() > 0 || exp1_q.size() > 0) && budget > 0) begin
            @(negedge CLK);
            budget--;
         end
         if (exp0_q.size() > 0 || exp1_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", exp0_q.size(), exp1_q.size());
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
